// File: rtl/pipe_ctrl_unit.sv
// ============================================================================
//  Module   : pipe_ctrl_unit
//  Purpose  : Pipeline scheduler for the five-stage ARM-subset core. Generates
//             hazard, freeze and flush strobes from RAW dependences,
//             multi-cycle data-memory accesses and taken branches, and keeps
//             saturating stall/flush counters for performance debug.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_ctrl_unit #(
    parameter int MEM_WAIT = 3,
    parameter bit FWD_EN   = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  id_rn,
    input  logic [3:0]  id_rm,
    input  logic        id_rn_valid,
    input  logic        id_two_src,
    input  logic        exe_wb_en,
    input  logic [3:0]  exe_dest,
    input  logic        exe_mem_read,
    input  logic        mem_wb_en,
    input  logic [3:0]  mem_dest,
    input  logic        mem_access,
    input  logic        exe_branch,
    output logic        hazard,
    output logic        freeze_if,
    output logic        freeze_id,
    output logic        freeze_exe,
    output logic        freeze_mem,
    output logic        flush,
    output logic        mem_rdy,
    output logic [1:0]  state,
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_count
);

    // Wait counter is at least one bit wide so that MEM_WAIT of 0 or 1 still
    // elaborates; it is simply never loaded with a non-zero value then.
    localparam int CNT_W = (MEM_WAIT < 2) ? 1 : $clog2(MEM_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD =
        (MEM_WAIT >= 2) ? CNT_W'(MEM_WAIT - 2) : '0;
    localparam logic HAS_WAIT  = (MEM_WAIT > 0);
    localparam logic MULTI_CYC = (MEM_WAIT >= 2);
    localparam logic ONE_WAIT  = (MEM_WAIT == 1);
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;

    logic w_rn_exe;
    logic w_rm_exe;
    logic w_rn_mem;
    logic w_rm_mem;
    logic w_raw_fwd;
    logic w_raw_nofwd;
    logic w_raw;
    logic w_mem_stall;

    // Source-register matches against the EXE and MEM destinations.
    always_comb begin
        w_rn_exe    = id_rn_valid & exe_wb_en & (exe_dest == id_rn);
        w_rm_exe    = id_two_src  & exe_wb_en & (exe_dest == id_rm);
        w_rn_mem    = id_rn_valid & mem_wb_en & (mem_dest == id_rn);
        w_rm_mem    = id_two_src  & mem_wb_en & (mem_dest == id_rm);
        // With forwarding only a load still in EXE cannot be bypassed.
        w_raw_fwd   = exe_mem_read & (w_rn_exe | w_rm_exe);
        w_raw_nofwd = w_rn_exe | w_rm_exe | w_rn_mem | w_rm_mem;
        w_raw       = FWD_EN ? w_raw_fwd : w_raw_nofwd;
    end

    // Stall/ready decode and stage strobes, all combinational from state.
    always_comb begin
        w_mem_stall = ((r_state == ST_IDLE) & mem_access & HAS_WAIT)
                    | (r_state == ST_WAIT);
        mem_rdy     = (r_state == ST_DONE)
                    | ((r_state == ST_IDLE) & mem_access & ~HAS_WAIT);
        // A taken branch kills the ID instruction, so no bubble is needed.
        hazard      = w_raw & ~exe_branch;
        freeze_id   = w_mem_stall;
        freeze_exe  = w_mem_stall;
        freeze_mem  = w_mem_stall;
        freeze_if   = w_mem_stall | hazard;
        // The branch stays in the frozen EXE register, so flushing in the
        // release cycle is enough; nothing has to be remembered.
        flush       = exe_branch & ~w_mem_stall;
        state       = r_state;
    end

    // Memory access sequencer: IDLE -> (WAIT*) -> DONE -> IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (mem_access && MULTI_CYC) begin
                        r_state <= ST_WAIT;
                        r_cnt   <= CNT_LOAD;
                    end else if (mem_access && ONE_WAIT) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Saturating performance counters for front-end stalls and flushes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (freeze_if && (stall_cycles != CNT_MAX)) begin
                stall_cycles <= stall_cycles + 16'd1;
            end
            if (flush && (flush_count != CNT_MAX)) begin
                flush_count <= flush_count + 16'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl_unit.sv
// ============================================================================
//  Module   : tb_pipe_ctrl_unit
//  Purpose  : Scoreboard bench for pipe_ctrl_unit. Three instances with
//             different MEM_WAIT/FWD_EN share one stimulus stream; a
//             behavioural model queues the expected outputs per cycle and a
//             monitor compares them on the falling clock edge.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pipe_ctrl_unit;

    typedef struct packed {
        logic        hz;
        logic        fif;
        logic        fid;
        logic        fex;
        logic        fme;
        logic        fl;
        logic        rdy;
        logic [1:0]  st;
        logic [15:0] sc;
        logic [15:0] fc;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] id_rn = '0, id_rm = '0, exe_dest = '0, mem_dest = '0;
    logic       id_rn_valid = 1'b0, id_two_src = 1'b0, exe_wb_en = 1'b0;
    logic       exe_mem_read = 1'b0, mem_wb_en = 1'b0, mem_access = 1'b0;
    logic       exe_branch = 1'b0;

    // Next-cycle stimulus, applied shortly after each rising edge.
    logic       nx_rst;
    logic [3:0] nx_id_rn, nx_id_rm, nx_exe_dest, nx_mem_dest;
    logic       nx_id_rn_valid, nx_id_two_src, nx_exe_wb_en, nx_exe_mem_read;
    logic       nx_mem_wb_en, nx_mem_access, nx_exe_branch;

    logic        a_hz, a_fif, a_fid, a_fex, a_fme, a_fl, a_rdy;
    logic [1:0]  a_st;
    logic [15:0] a_sc, a_fc;
    logic        b_hz, b_fif, b_fid, b_fex, b_fme, b_fl, b_rdy;
    logic [1:0]  b_st;
    logic [15:0] b_sc, b_fc;
    logic        c_hz, c_fif, c_fid, c_fex, c_fme, c_fl, c_rdy;
    logic [1:0]  c_st;
    logic [15:0] c_sc, c_fc;

    obs_t act_a, act_b, act_c;
    assign act_a = {a_hz, a_fif, a_fid, a_fex, a_fme, a_fl, a_rdy, a_st, a_sc, a_fc};
    assign act_b = {b_hz, b_fif, b_fid, b_fex, b_fme, b_fl, b_rdy, b_st, b_sc, b_fc};
    assign act_c = {c_hz, c_fif, c_fid, c_fex, c_fme, c_fl, c_rdy, c_st, c_sc, c_fc};

    pipe_ctrl_unit #(.MEM_WAIT(3), .FWD_EN(1'b0)) u_a (
        .clk(clk), .rst(rst), .id_rn(id_rn), .id_rm(id_rm),
        .id_rn_valid(id_rn_valid), .id_two_src(id_two_src),
        .exe_wb_en(exe_wb_en), .exe_dest(exe_dest), .exe_mem_read(exe_mem_read),
        .mem_wb_en(mem_wb_en), .mem_dest(mem_dest), .mem_access(mem_access),
        .exe_branch(exe_branch), .hazard(a_hz), .freeze_if(a_fif),
        .freeze_id(a_fid), .freeze_exe(a_fex), .freeze_mem(a_fme),
        .flush(a_fl), .mem_rdy(a_rdy), .state(a_st),
        .stall_cycles(a_sc), .flush_count(a_fc));

    pipe_ctrl_unit #(.MEM_WAIT(0), .FWD_EN(1'b1)) u_b (
        .clk(clk), .rst(rst), .id_rn(id_rn), .id_rm(id_rm),
        .id_rn_valid(id_rn_valid), .id_two_src(id_two_src),
        .exe_wb_en(exe_wb_en), .exe_dest(exe_dest), .exe_mem_read(exe_mem_read),
        .mem_wb_en(mem_wb_en), .mem_dest(mem_dest), .mem_access(mem_access),
        .exe_branch(exe_branch), .hazard(b_hz), .freeze_if(b_fif),
        .freeze_id(b_fid), .freeze_exe(b_fex), .freeze_mem(b_fme),
        .flush(b_fl), .mem_rdy(b_rdy), .state(b_st),
        .stall_cycles(b_sc), .flush_count(b_fc));

    pipe_ctrl_unit #(.MEM_WAIT(1), .FWD_EN(1'b1)) u_c (
        .clk(clk), .rst(rst), .id_rn(id_rn), .id_rm(id_rm),
        .id_rn_valid(id_rn_valid), .id_two_src(id_two_src),
        .exe_wb_en(exe_wb_en), .exe_dest(exe_dest), .exe_mem_read(exe_mem_read),
        .mem_wb_en(mem_wb_en), .mem_dest(mem_dest), .mem_access(mem_access),
        .exe_branch(exe_branch), .hazard(c_hz), .freeze_if(c_fif),
        .freeze_id(c_fid), .freeze_exe(c_fex), .freeze_mem(c_fme),
        .flush(c_fl), .mem_rdy(c_rdy), .state(c_st),
        .stall_cycles(c_sc), .flush_count(c_fc));

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    obs_t q_a[$];
    obs_t q_b[$];
    obs_t q_c[$];

    // Reference model: each instance tracks how many cycles its current
    // access has spent in MEM (-1 = no access in progress).
    int mw [3] = '{3, 0, 1};
    int fw [3] = '{0, 1, 1};
    int age[3] = '{-1, -1, -1};
    int sc [3] = '{0, 0, 0};
    int fc [3] = '{0, 0, 0};

    function automatic obs_t model_out(int k);
        obs_t o;
        bit rn_e, rm_e, rn_m, rm_m, raw, stall, rdy;
        int st;
        rn_e = id_rn_valid && exe_wb_en && (exe_dest == id_rn);
        rm_e = id_two_src  && exe_wb_en && (exe_dest == id_rm);
        rn_m = id_rn_valid && mem_wb_en && (mem_dest == id_rn);
        rm_m = id_two_src  && mem_wb_en && (mem_dest == id_rm);
        if (fw[k] != 0) raw = exe_mem_read && (rn_e || rm_e);
        else            raw = rn_e || rm_e || rn_m || rm_m;
        if (age[k] < 0) begin
            st    = 0;
            stall = mem_access && (mw[k] > 0);
            rdy   = mem_access && (mw[k] == 0);
        end else begin
            st    = (age[k] == mw[k]) ? 2 : 1;
            stall = (age[k] < mw[k]);
            rdy   = (age[k] == mw[k]);
        end
        o.hz  = raw && !exe_branch;
        o.fif = stall || o.hz;
        o.fid = stall;
        o.fex = stall;
        o.fme = stall;
        o.fl  = exe_branch && !stall;
        o.rdy = rdy;
        o.st  = 2'(st);
        o.sc  = 16'(sc[k]);
        o.fc  = 16'(fc[k]);
        return o;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 3; k++) begin
            age[k] = -1;
            sc[k]  = 0;
            fc[k]  = 0;
        end
    endfunction

    // Advance the model across one rising edge using the inputs present there.
    function automatic void model_edge();
        obs_t o;
        if (!rst) begin
            model_reset();
        end else begin
            for (int k = 0; k < 3; k++) begin
                o = model_out(k);
                if (o.fif && sc[k] < 65535) sc[k]++;
                if (o.fl  && fc[k] < 65535) fc[k]++;
                if (age[k] < 0) begin
                    if (mem_access && mw[k] > 0) age[k] = 1;
                end else if (age[k] < mw[k]) begin
                    age[k]++;
                end else begin
                    age[k] = -1;
                end
            end
        end
    endfunction

    function automatic void push_expected();
        q_a.push_back(model_out(0));
        q_b.push_back(model_out(1));
        q_c.push_back(model_out(2));
    endfunction

    task automatic set_idle();
        nx_id_rn = '0; nx_id_rm = '0; nx_exe_dest = '0; nx_mem_dest = '0;
        nx_id_rn_valid = 1'b0; nx_id_two_src = 1'b0; nx_exe_wb_en = 1'b0;
        nx_exe_mem_read = 1'b0; nx_mem_wb_en = 1'b0; nx_mem_access = 1'b0;
        nx_exe_branch = 1'b0;
    endtask

    // One cycle: update the model at the edge, apply the next stimulus, and
    // optionally pull reset low between edges before queueing expectations.
    task automatic drive_cycle(input bit mid_reset);
        @(posedge clk);
        model_edge();
        #1;
        rst = nx_rst;
        id_rn = nx_id_rn; id_rm = nx_id_rm;
        id_rn_valid = nx_id_rn_valid; id_two_src = nx_id_two_src;
        exe_wb_en = nx_exe_wb_en; exe_dest = nx_exe_dest;
        exe_mem_read = nx_exe_mem_read; mem_wb_en = nx_mem_wb_en;
        mem_dest = nx_mem_dest; mem_access = nx_mem_access;
        exe_branch = nx_exe_branch;
        if (mid_reset) begin
            #2;
            rst = 1'b0;
            mem_access = 1'b0;
            nx_rst = 1'b0;
            nx_mem_access = 1'b0;
            model_reset();
        end
        push_expected();
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare(input string tag, input obs_t e, input obs_t a);
        chk({tag, ".hazard"},       a.hz,  e.hz);
        chk({tag, ".freeze_if"},    a.fif, e.fif);
        chk({tag, ".freeze_id"},    a.fid, e.fid);
        chk({tag, ".freeze_exe"},   a.fex, e.fex);
        chk({tag, ".freeze_mem"},   a.fme, e.fme);
        chk({tag, ".flush"},        a.fl,  e.fl);
        chk({tag, ".mem_rdy"},      a.rdy, e.rdy);
        chk({tag, ".state"},        a.st,  e.st);
        chk({tag, ".stall_cycles"}, a.sc,  e.sc);
        chk({tag, ".flush_count"},  a.fc,  e.fc);
    endtask

    // Monitor: one expected record per instance per cycle, away from the edge.
    obs_t e_mon;
    always @(negedge clk) begin
        if (q_a.size() > 0) begin e_mon = q_a.pop_front(); compare("A", e_mon, act_a); end
        if (q_b.size() > 0) begin e_mon = q_b.pop_front(); compare("B", e_mon, act_b); end
        if (q_c.size() > 0) begin e_mon = q_c.pop_front(); compare("C", e_mon, act_c); end
    end

    initial begin
        nx_rst = 1'b0;
        set_idle();
        repeat (2) drive_cycle(1'b0);
        nx_rst = 1'b1;
        repeat (2) drive_cycle(1'b0);

        // RAW without forwarding, then a non-matching destination.
        nx_exe_wb_en = 1'b1; nx_exe_dest = 4'd4; nx_id_rn = 4'd4; nx_id_rn_valid = 1'b1;
        drive_cycle(1'b0);
        nx_exe_dest = 4'd5;
        drive_cycle(1'b0);

        // Load-use on Rm, then plain ALU producer, then MEM-stage producer.
        set_idle();
        nx_exe_wb_en = 1'b1; nx_exe_mem_read = 1'b1; nx_exe_dest = 4'd2;
        nx_id_two_src = 1'b1; nx_id_rm = 4'd2;
        drive_cycle(1'b0);
        nx_exe_mem_read = 1'b0;
        drive_cycle(1'b0);
        nx_exe_wb_en = 1'b0; nx_mem_wb_en = 1'b1; nx_mem_dest = 4'd2;
        drive_cycle(1'b0);

        // Multi-cycle access with a taken branch arriving mid-stall.
        set_idle();
        repeat (3) drive_cycle(1'b0);
        nx_mem_access = 1'b1;
        drive_cycle(1'b0);
        nx_exe_branch = 1'b1;
        repeat (3) drive_cycle(1'b0);
        set_idle();
        repeat (2) drive_cycle(1'b0);

        // Branch coinciding with a RAW: flush wins, no bubble.
        nx_exe_wb_en = 1'b1; nx_exe_dest = 4'd7; nx_id_rn = 4'd7; nx_id_rn_valid = 1'b1;
        nx_exe_mem_read = 1'b1; nx_exe_branch = 1'b1;
        drive_cycle(1'b0);
        set_idle();

        // Reset dropped between edges while the access is in WAIT.
        nx_mem_access = 1'b1;
        drive_cycle(1'b0);
        drive_cycle(1'b1);
        drive_cycle(1'b0);
        nx_rst = 1'b1;
        drive_cycle(1'b0);
        nx_mem_access = 1'b1;
        repeat (5) drive_cycle(1'b0);
        set_idle();
        drive_cycle(1'b0);

        // Randomized traffic with narrow register ranges to provoke matches.
        for (int i = 0; i < 400; i++) begin
            nx_id_rn        = 4'($urandom_range(0, 3));
            nx_id_rm        = 4'($urandom_range(0, 3));
            nx_exe_dest     = 4'($urandom_range(0, 3));
            nx_mem_dest     = 4'($urandom_range(0, 3));
            nx_id_rn_valid  = 1'($urandom_range(0, 1));
            nx_id_two_src   = 1'($urandom_range(0, 1));
            nx_exe_wb_en    = 1'($urandom_range(0, 1));
            nx_exe_mem_read = 1'($urandom_range(0, 1));
            nx_mem_wb_en    = 1'($urandom_range(0, 1));
            nx_mem_access   = ($urandom_range(0, 99) < 40);
            nx_exe_branch   = ($urandom_range(0, 99) < 20);
            if (!nx_rst) nx_rst = 1'b1;
            drive_cycle($urandom_range(0, 99) == 0);
        end

        set_idle();
        drive_cycle(1'b0);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", q_a.size() + q_b.size() + q_c.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pipe_ctrl_unit.md
# pipe_ctrl_unit

Central pipeline scheduler for the five-stage ARM-subset core. Each cycle it decides the freeze, flush and hazard strobes for the IF, ID, EXE and MEM stage registers. Inputs are RAW dependences between the instruction in ID and the instructions in EXE/MEM, multi-cycle data-memory accesses and taken branches resolved in EXE. It also keeps saturating stall and flush counters for performance debug.

## Interface
- MEM_WAIT, 3: stall cycles inserted per data-memory access (0 = single-cycle memory, no stall).
- FWD_EN, 0: 1 = forwarding present; only load-use dependences in EXE raise hazard.

- clk  input  1  core clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-low
- id_rn, id_rm  input  4  source registers of the instruction in ID
- id_rn_valid  input  1  Rn is read by the ID instruction
- id_two_src  input  1  Rm (or store data register) is read
- exe_wb_en, exe_dest[3:0], exe_mem_read  input  1/4/1  EXE-stage write-back enable, destination, load flag
- mem_wb_en, mem_dest[3:0]  input  1/4  MEM-stage write-back enable, destination
- mem_access  input  1  instruction in MEM performs a load or store
- exe_branch  input  1  taken branch resolved in EXE
- hazard  output  1  to ID stage: insert bubble (zero control signals)
- freeze_if  output  1  hold PC and IF/ID register
- freeze_id, freeze_exe, freeze_mem  output  1  hold ID/EXE, EXE/MEM, MEM/WB registers
- flush  output  1  clear IF/ID and ID/EXE registers
- mem_rdy  output  1  memory access completes this cycle
- state  output  2  FSM state (0 IDLE, 1 WAIT, 2 DONE)
- stall_cycles  output  16  cycles with freeze_if high, saturating
- flush_count  output  16  cycles with flush high, saturating

## Operation
- RAW detection (combinational), FWD_EN=0: raw = (id_rn_valid & exe_wb_en & exe_dest==id_rn) | (id_two_src & exe_wb_en & exe_dest==id_rm) | the same two terms for the MEM stage.
- FWD_EN=1: raw = exe_mem_read & exe_wb_en & ((id_rn_valid & exe_dest==id_rn) | (id_two_src & exe_dest==id_rm)). MEM-stage terms are ignored.
- hazard = raw & ~exe_branch. A taken branch kills the ID instruction anyway.
- Memory FSM, counter cnt of width clog2(MEM_WAIT+1):
  - IDLE: if mem_access & MEM_WAIT≥2 → WAIT, cnt=MEM_WAIT-2. If mem_access & MEM_WAIT==1 → DONE. Otherwise stay in IDLE.
  - WAIT: if cnt==0 → DONE, else cnt−1.
  - DONE: → IDLE unconditionally. mem_access is not sampled in DONE.
- mem_stall = (IDLE & mem_access & MEM_WAIT>0) | WAIT.
- mem_rdy = DONE, or IDLE & mem_access when MEM_WAIT==0.
- freeze_id = freeze_exe = freeze_mem = mem_stall.
- freeze_if = mem_stall | hazard.
- flush = exe_branch & ~mem_stall. A branch frozen in EXE stays asserted, so the flush takes effect in the release cycle; no latching is needed.
- Counters increment at the clock edge when their condition is high and hold at 16'hFFFF.

## Timing
- Reset (async, rst=0): state=IDLE, cnt=0, stall_cycles=0, flush_count=0. Combinational outputs follow the inputs with state=IDLE.
- Reset asserted mid-WAIT aborts the access: freezes drop in the same cycle, and the MEM instruction is lost. This is intended, because the whole core resets.
- An access first seen at cycle T:
  - mem_stall is high for T..T+MEM_WAIT−1.
  - At T+MEM_WAIT, mem_rdy=1 and mem_stall=0, and all stages advance at the end of that cycle.
  - The instruction therefore occupies MEM for MEM_WAIT+1 cycles.
- Back-to-back accesses: the next access enters MEM after DONE and is seen in IDLE at T+MEM_WAIT+1. There is no idle bubble between accesses.
- hazard, freeze_* and flush have zero latency: they are combinational from inputs and state.
- Simultaneous RAW and mem_stall: both freeze_if and hazard are high. The bubble is absorbed because ID/EXE is frozen.
- Simultaneous exe_branch and RAW: flush=1 and hazard=0.

## Test plan
- RAW, FWD_EN=0: exe_wb_en=1, exe_dest=4, id_rn=4, id_rn_valid=1 → hazard=1, freeze_if=1, freeze_id=0. Change to exe_dest=5 → hazard=0.
- Load-use, FWD_EN=1: exe_mem_read=1, exe_dest=2, id_two_src=1, id_rm=2 → hazard=1. Clear exe_mem_read → hazard=0. Check that a MEM-stage match gives hazard=0.
- Memory stall, MEM_WAIT=3: hold mem_access high from cycle 10 → freezes high for cycles 10–12, mem_rdy=1 at cycle 13, state sequence IDLE, WAIT, WAIT, DONE, IDLE. Check stall_cycles=3 afterwards.
- Branch during stall: exe_branch=1 at cycle 11 within the above → flush=0 on cycles 11–12, flush=1 on cycle 13, flush_count=1.
- MEM_WAIT=0: mem_access=1 → no freeze, mem_rdy=1 in the same cycle, state stays IDLE.
- Async reset mid-WAIT: drop rst at cycle 11 (between edges) → state=IDLE and freezes=0 immediately, counters=0. Release rst → normal operation on the next access.
